// File: rtl/spl_pkg.sv
// Shared definitions for the serial-parallel LED output block:
// FSM state encoding and a counter-width helper.
package spl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } spl_state_e;

    // Returns at least 1 so that a counter for a modulus of 1 still has a bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/spl_clk_div.sv
// Half-period tick generator for the LED shift clock: pulses tick once
// every CLK_DIV cycles, realigned to zero whenever restart is high.
module spl_clk_div
    import spl_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    assign at_end = (cnt == CNT_W'(CLK_DIV - 1));
    assign tick   = at_end && !restart;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spl_shift_out.sv
// Serialises a parallel word onto the LED shift-register chain with a
// one-deep pending-frame buffer, and holds a parallel GPIO register.
module spl_shift_out
    import spl_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int GPIO_W    = 32,
    parameter int CLK_DIV   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [DATA_W-1:0] p_data,
    output logic              led_clk,
    output logic              led_sout,
    output logic              led_clrn,
    output logic              led_pen,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              busy,
    output logic              done
);

    localparam int BCNT_W = clog2(DATA_W + 1);

    spl_state_e        state, state_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic [DATA_W-1:0] pend_data, pend_data_nx;
    logic              pend_valid, pend_valid_nx;
    logic              phase_high, phase_nx;
    logic [BCNT_W-1:0] bit_cnt, bit_cnt_nx;
    logic              pen_q, pen_nx;
    logic              clrn_q;
    logic              restart;
    logic              tick;
    logic [DATA_W-1:0] shifted;

    spl_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    // The bit on the wire always sits at the outgoing end of the shift register.
    assign shifted  = (MSB_FIRST != 0) ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};
    assign led_sout = (MSB_FIRST != 0) ? shreg[DATA_W-1] : shreg[0];
    assign led_clk  = (state == ST_SHIFT) && phase_high;
    assign led_pen  = pen_q;
    assign led_clrn = clrn_q;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        shreg_nx      = shreg;
        pend_data_nx  = pend_data;
        pend_valid_nx = pend_valid;
        phase_nx      = phase_high;
        bit_cnt_nx    = bit_cnt;
        pen_nx        = pen_q;
        restart       = 1'b0;
        done          = 1'b0;

        if (start && (state != ST_IDLE)) begin
            pend_data_nx  = p_data;
            pend_valid_nx = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    shreg_nx = p_data;
                    pen_nx   = 1'b0;
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                restart    = 1'b1;
                bit_cnt_nx = BCNT_W'(DATA_W);
                phase_nx   = 1'b0;
                state_nx   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_high) begin
                        phase_nx = 1'b1;
                    end else begin
                        phase_nx = 1'b0;
                        if (bit_cnt == BCNT_W'(1)) begin
                            pen_nx   = 1'b1;
                            state_nx = ST_LATCH;
                        end else begin
                            bit_cnt_nx = bit_cnt - BCNT_W'(1);
                            shreg_nx   = shifted;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    done = 1'b1;
                    // A start arriving now is newer than any stored frame.
                    if (start || pend_valid) begin
                        shreg_nx      = start ? p_data : pend_data;
                        pend_valid_nx = 1'b0;
                        pen_nx        = 1'b0;
                        state_nx      = ST_LOAD;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            phase_high <= 1'b0;
            bit_cnt    <= '0;
            pen_q      <= 1'b0;
            clrn_q     <= 1'b0;
            gpio_out   <= '0;
        end else begin
            shreg      <= shreg_nx;
            pend_data  <= pend_data_nx;
            pend_valid <= pend_valid_nx;
            phase_high <= phase_nx;
            bit_cnt    <= bit_cnt_nx;
            pen_q      <= pen_nx;
            clrn_q     <= 1'b1;
            if (en) begin
                gpio_out <= p_data[GPIO_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_spl_shift_out.sv
// Bench for spl_shift_out: four differently parameterised instances share
// the stimulus and are compared every cycle against a frame-position model.
module tb_spl_shift_out;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        en    = 1'b0;
    logic [63:0] pd    = '0;
    logic        checking = 1'b0;

    int tests = 0;
    int fails = 0;

    wire [3:0]  lc, ls, lcr, lp, bz, dn;
    wire [7:0]  g0;
    wire [4:0]  g1;
    wire [3:0]  g2;
    wire [15:0] g3;

    always #5 clk = ~clk;

    spl_shift_out #(.DATA_W(8), .GPIO_W(8), .CLK_DIV(1), .MSB_FIRST(1)) u0 (
        .clk(clk), .rst(rst), .start(start), .en(en), .p_data(pd[7:0]),
        .led_clk(lc[0]), .led_sout(ls[0]), .led_clrn(lcr[0]), .led_pen(lp[0]),
        .gpio_out(g0), .busy(bz[0]), .done(dn[0]));

    spl_shift_out #(.DATA_W(8), .GPIO_W(5), .CLK_DIV(2), .MSB_FIRST(0)) u1 (
        .clk(clk), .rst(rst), .start(start), .en(en), .p_data(pd[7:0]),
        .led_clk(lc[1]), .led_sout(ls[1]), .led_clrn(lcr[1]), .led_pen(lp[1]),
        .gpio_out(g1), .busy(bz[1]), .done(dn[1]));

    spl_shift_out #(.DATA_W(4), .GPIO_W(4), .CLK_DIV(3), .MSB_FIRST(0)) u2 (
        .clk(clk), .rst(rst), .start(start), .en(en), .p_data(pd[3:0]),
        .led_clk(lc[2]), .led_sout(ls[2]), .led_clrn(lcr[2]), .led_pen(lp[2]),
        .gpio_out(g2), .busy(bz[2]), .done(dn[2]));

    spl_shift_out #(.DATA_W(32), .GPIO_W(16), .CLK_DIV(1), .MSB_FIRST(1)) u3 (
        .clk(clk), .rst(rst), .start(start), .en(en), .p_data(pd[31:0]),
        .led_clk(lc[3]), .led_sout(ls[3]), .led_clrn(lcr[3]), .led_pen(lp[3]),
        .gpio_out(g3), .busy(bz[3]), .done(dn[3]));

    function automatic int cfgDw(input int i);
        case (i)
            0: return 8;
            1: return 8;
            2: return 4;
            default: return 32;
        endcase
    endfunction

    function automatic int cfgGw(input int i);
        case (i)
            0: return 8;
            1: return 5;
            2: return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int cfgCd(input int i);
        case (i)
            0: return 1;
            1: return 2;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit cfgMsb(input int i);
        return (i == 0) || (i == 3);
    endfunction

    function automatic logic [63:0] gpioAct(input int i);
        case (i)
            0: return 64'(g0);
            1: return 64'(g1);
            2: return 64'(g2);
            default: return 64'(g3);
        endcase
    endfunction

    function automatic logic [63:0] widthMask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic int frameLen(input int i);
        return 1 + 2 * cfgCd(i) * cfgDw(i) + cfgCd(i);
    endfunction

    // Model: each instance is either idle or at a position within its frame.
    logic        m_busy [4];
    int          m_pos  [4];
    logic [63:0] m_frame[4];
    logic        m_pv   [4];
    logic [63:0] m_pend [4];
    logic        m_pen  [4];
    logic [63:0] m_gpio [4];
    logic        m_clrn;

    function automatic logic sentBit(input int i, input int k);
        return cfgMsb(i) ? m_frame[i][cfgDw(i) - 1 - k] : m_frame[i][k];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            m_busy[i]  = 1'b0;
            m_pos[i]   = 0;
            m_frame[i] = '0;
            m_pv[i]    = 1'b0;
            m_pend[i]  = '0;
            m_pen[i]   = 1'b0;
            m_gpio[i]  = '0;
        end
        m_clrn = 1'b0;
    endtask

    task automatic modelStep();
        logic [63:0] d;
        m_clrn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (en) m_gpio[i] = pd & widthMask(cfgGw(i));
            d = pd & widthMask(cfgDw(i));
            if (!m_busy[i]) begin
                if (start) begin
                    m_busy[i]  = 1'b1;
                    m_pos[i]   = 0;
                    m_frame[i] = d;
                end
            end else begin
                if (start) begin
                    m_pend[i] = d;
                    m_pv[i]   = 1'b1;
                end
                if (m_pos[i] == frameLen(i) - 1) begin
                    m_pen[i] = 1'b1;
                    if (m_pv[i]) begin
                        m_frame[i] = m_pend[i];
                        m_pv[i]    = 1'b0;
                        m_pos[i]   = 0;
                    end else begin
                        m_busy[i] = 1'b0;
                    end
                end else begin
                    m_pos[i]++;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) modelReset();
        else      modelStep();
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs packed as {led_clk, led_sout, led_clrn, led_pen, busy, done, gpio}.
    function automatic logic [127:0] expected(input int i);
        int  p, ncd, c2;
        logic e_clk, e_sout, e_pen, e_done;
        p   = m_pos[i];
        c2  = 2 * cfgCd(i);
        ncd = c2 * cfgDw(i);
        e_clk  = 1'b0;
        e_done = 1'b0;
        if (!m_busy[i]) begin
            e_sout = sentBit(i, cfgDw(i) - 1);
            e_pen  = m_pen[i];
        end else begin
            e_pen  = (p > ncd);
            e_done = (p == frameLen(i) - 1);
            if (p == 0) begin
                e_sout = sentBit(i, 0);
            end else if (p <= ncd) begin
                e_sout = sentBit(i, (p - 1) / c2);
                e_clk  = (((p - 1) % c2) >= cfgCd(i));
            end else begin
                e_sout = sentBit(i, cfgDw(i) - 1);
            end
        end
        return {58'd0, e_clk, e_sout, m_clrn, e_pen, m_busy[i], e_done, m_gpio[i]};
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("inst%0d_outputs", i),
                            {58'd0, lc[i], ls[i], lcr[i], lp[i], bz[i], dn[i], gpioAct(i)},
                            expected(i));
            end
        end
    end

    task automatic applyStimulus(input logic s, input logic e, input logic [63:0] d);
        @(posedge clk);
        #2;
        start = s;
        en    = e;
        pd    = d;
    endtask

    // Observation of a directed run; cycle 1 is the cycle after start is sampled.
    logic [63:0] w_bits[4];
    logic [63:0] w_shl [4];
    int          w_k   [4];
    int          w_dcnt[4];
    int          w_dfirst[4];
    logic [63:0] w_pen0;

    task automatic watchFrames(input int budget);
        logic [3:0] prev;
        bit         finished;
        prev     = lc;
        finished = 0;
        w_pen0   = '0;
        for (int i = 0; i < 4; i++) begin
            w_bits[i] = '0; w_shl[i] = '0; w_k[i] = 0; w_dcnt[i] = 0; w_dfirst[i] = -1;
        end
        for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (lc[i] && !prev[i] && w_k[i] < 64) begin
                    w_bits[i][w_k[i]] = ls[i];
                    w_shl[i] = {w_shl[i][62:0], ls[i]};
                    w_k[i]++;
                end
                if (dn[i]) begin
                    w_dcnt[i]++;
                    if (w_dfirst[i] < 0) w_dfirst[i] = cyc;
                end
            end
            if (cyc < 64) w_pen0[cyc] = lp[0];
            prev = lc;
            if (cyc > 1 && bz == 4'b0000) finished = 1;
        end
        checkOutput("watch_completes", 128'(finished), 128'd1);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 checking = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("clrn_first_cycle", 128'(lcr), 128'h0);
        @(negedge clk);
        checkOutput("clrn_after", 128'(lcr), 128'hF);

        applyStimulus(1'b1, 1'b0, 64'hA5);
        applyStimulus(1'b0, 1'b0, 64'h0);
        watchFrames(200);
        checkOutput("a5_msb_bits",   128'(w_shl[0][7:0]),  128'hA5);
        checkOutput("a5_lsb_bits",   128'(w_bits[1][7:0]), 128'hA5);
        checkOutput("a5_nibble",     128'(w_bits[2][3:0]), 128'h5);
        checkOutput("a5_done_cycle", 128'(w_dfirst[0]),    128'd18);
        checkOutput("pen_cycle1",    128'(w_pen0[1]),      128'd0);
        checkOutput("pen_cycle17",   128'(w_pen0[17]),     128'd0);
        checkOutput("pen_cycle18",   128'(w_pen0[18]),     128'd1);
        checkOutput("div3_done",     128'(w_dfirst[2]),    128'd28);

        applyStimulus(1'b1, 1'b0, 64'h01);
        applyStimulus(1'b0, 1'b0, 64'h0);
        watchFrames(200);
        checkOutput("lsb_first_01", 128'(w_bits[1][7:0]), 128'h01);
        checkOutput("msb_first_01", 128'(w_shl[0][7:0]),  128'h01);

        applyStimulus(1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 64'h0);
        @(negedge clk);
        checkOutput("gpio_beef", 128'(g3), 128'hBEEF);
        checkOutput("gpio_idle", 128'({bz, lc}), 128'h0);

        applyStimulus(1'b1, 1'b0, 64'h11);
        applyStimulus(1'b0, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h22);
        applyStimulus(1'b0, 1'b0, 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h33);
        applyStimulus(1'b0, 1'b0, 64'h0);
        watchFrames(400);
        checkOutput("pending_frame", 128'(w_shl[0][7:0]), 128'h33);
        checkOutput("pending_dones", 128'(w_dcnt[0]),     128'd2);

        for (int n = 0; n < 6000; n++) begin
            int span;
            span = (n < 2000) ? 3 : ((n < 4000) ? 12 : 40);
            applyStimulus($urandom_range(0, span - 1) == 0, $urandom_range(0, 7) == 0,
                          {$urandom, $urandom});
            if ($urandom_range(0, 599) == 0) begin
                @(posedge clk);
                #3 rst = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2 rst = 1'b1;
            end
        end
        applyStimulus(1'b0, 1'b0, 64'h0);
        repeat (150) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
